fetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the decode stage and produces `IF_ID_IR`/`IF_ID_NPC`. It issues word fetches to a variable-latency instruction memory over a req/ack handshake, buffers returned instructions in a small prefetch queue, and presents them through the IF/ID register. It honours the load-use `hazard` stall and flushes on a taken branch (`branch_taken`, `branch_target`) from EX/MEM.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_queue_if.sv | 12 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = '0;

  typedef enum logic [1:0] {FETCH, WAIT, DROP} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] npc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and memory (slave).
interface fetch_queue_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {instr, npc}; simultaneous push and pop allowed at any occupancy.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: request FSM, pc, prefetch queue and the IF/ID register.
// state | meaning
// FETCH | idle; issue a request when the queue has room
// WAIT  | request outstanding; data is kept on ack
// DROP  | request outstanding after a redirect; data is discarded on ack
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  fetch_queue_if.master    imem,
  output logic [XLEN-1:0]  IF_ID_IR,
  output logic [XLEN-1:0]  IF_ID_NPC,
  output logic             IF_ID_valid
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] addr_nxt;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            room_after;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  assign addr_nxt        = imem.imem_addr + XLEN'(4);
  assign push            = (state == WAIT) && imem.imem_ack && !branch_taken;
  assign pop             = !empty && !hazard && !branch_taken;
  // Occupancy after this edge's push and pop still leaves a free slot.
  assign room_after      = (count - CW'(pop)) < CW'(DEPTH - 1);
  assign push_data.instr = imem.imem_rdata;
  assign push_data.npc   = addr_nxt;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (branch_taken),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= RESET_PC;
    end else begin
      case (state)
        FETCH: begin
          if (branch_taken) begin
            pc             <= branch_target;
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= branch_target;
            state          <= WAIT;
          end else if (!full) begin
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= pc;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (branch_taken) begin
            pc <= branch_target;
            if (imem.imem_ack) begin
              imem.imem_req <= 1'b0;
              state         <= FETCH;
            end else begin
              state <= DROP;
            end
          end else if (imem.imem_ack) begin
            pc <= addr_nxt;
            if (room_after) begin
              imem.imem_addr <= addr_nxt;
            end else begin
              imem.imem_req <= 1'b0;
              state         <= FETCH;
            end
          end
        end
        DROP: begin
          if (branch_taken) pc <= branch_target;
          if (imem.imem_ack) begin
            imem.imem_req <= 1'b0;
            state         <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IF_ID_IR    <= NOP;
      IF_ID_NPC   <= '0;
      IF_ID_valid <= 1'b0;
    end else if (branch_taken) begin
      IF_ID_IR    <= NOP;
      IF_ID_valid <= 1'b0;
    end else if (!hazard) begin
      if (!empty) begin
        IF_ID_IR    <= head.instr;
        IF_ID_NPC   <= head.npc;
        IF_ID_valid <= 1'b1;
      end else begin
        IF_ID_IR    <= NOP;
        IF_ID_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, stall, redirects, address wrap and async reset.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ack_en;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch_queue_if imem ();

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem.imem_ack   = imem.imem_req & ack_en;
  assign imem.imem_rdata = word(imem.imem_addr);

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .hazard        (hazard),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem),
    .IF_ID_IR      (if_id_ir),
    .IF_ID_NPC     (if_id_npc),
    .IF_ID_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic ack);
    reset = 1'b0; hazard = 1'b0; branch_taken = 1'b0; branch_target = '0; ack_en = ack;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [64:0] exp_ifid;
    reset = 1'b0; hazard = 1'b0; branch_taken = 1'b0; branch_target = '0; ack_en = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({imem.imem_req, imem.imem_addr} !== {1'b0, 32'h0}) begin
      n_bad++; $display("FAIL reset_bus got %h want %h", {imem.imem_req, imem.imem_addr}, {1'b0, 32'h0});
    end
    exp_ifid = '0;
    n_cmp++;
    if ({if_id_ir, if_id_npc, if_id_valid} !== exp_ifid) begin
      n_bad++; $display("FAIL reset_ifid got %h want %h", {if_id_ir, if_id_npc, if_id_valid}, exp_ifid);
    end
    #2 reset = 1'b1;
    tick();
    n_cmp++;
    if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL reset_first_req got %h want %h", {imem.imem_req, imem.imem_addr}, {1'b1, 32'h0});
    end
  endtask

  task automatic test_stream();
    logic [32:0] exp_bus;
    logic [64:0] exp_ifid;
    apply_reset(1'b1);
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_bus = {1'b1, 32'(4 * (n - 1))};
      n_cmp++;
      if ({imem.imem_req, imem.imem_addr} !== exp_bus) begin
        n_bad++; $display("FAIL stream_addr edge=%0d got %h want %h", n, {imem.imem_req, imem.imem_addr}, exp_bus);
      end
      if (n >= 3) begin
        exp_ifid = {word(32'(4 * (n - 3))), 32'(4 * (n - 2)), 1'b1};
        n_cmp++;
        if ({if_id_ir, if_id_npc, if_id_valid} !== exp_ifid) begin
          n_bad++; $display("FAIL stream_ifid edge=%0d got %h want %h", n, {if_id_ir, if_id_npc, if_id_valid}, exp_ifid);
        end
      end else begin
        n_cmp++;
        if (if_id_valid !== 1'b0) begin
          n_bad++; $display("FAIL stream_bubble edge=%0d got %b want 0", n, if_id_valid);
        end
      end
    end
  endtask

  task automatic test_hazard();
    logic [64:0] exp_ifid;
    apply_reset(1'b1);
    repeat (4) tick();
    hazard = 1'b1;
    for (int e = 5; e <= 10; e++) begin
      tick();
      exp_ifid = {word(32'h4), 32'h8, 1'b1};
      n_cmp++;
      if ({if_id_ir, if_id_npc, if_id_valid} !== exp_ifid) begin
        n_bad++; $display("FAIL hazard_hold edge=%0d got %h want %h", e, {if_id_ir, if_id_npc, if_id_valid}, exp_ifid);
      end
      n_cmp++;
      if (imem.imem_req !== (e < 7)) begin
        n_bad++; $display("FAIL hazard_req edge=%0d got %b want %b", e, imem.imem_req, (e < 7));
      end
    end
    hazard = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_ifid = {word(32'(8 + 4 * k)), 32'(12 + 4 * k), 1'b1};
      n_cmp++;
      if ({if_id_ir, if_id_npc, if_id_valid} !== exp_ifid) begin
        n_bad++; $display("FAIL hazard_drain k=%0d got %h want %h", k, {if_id_ir, if_id_npc, if_id_valid}, exp_ifid);
      end
      if (k == 1) begin
        n_cmp++;
        if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'd24}) begin
          n_bad++; $display("FAIL hazard_resume got %h want %h", {imem.imem_req, imem.imem_addr}, {1'b1, 32'd24});
        end
      end
    end
  endtask

  task automatic test_branch_wait();
    logic [64:0] exp_ifid;
    apply_reset(1'b0);
    tick();
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    for (int e = 2; e <= 4; e++) begin
      if (e > 2) tick();
      n_cmp++;
      if ({imem.imem_req, imem.imem_addr, if_id_valid} !== {1'b1, 32'h0, 1'b0}) begin
        n_bad++; $display("FAIL drop_hold edge=%0d got %h want %h", e, {imem.imem_req, imem.imem_addr, if_id_valid}, {1'b1, 32'h0, 1'b0});
      end
    end
    ack_en = 1'b1;
    tick();
    n_cmp++;
    if ({imem.imem_req, if_id_valid} !== 2'b00) begin
      n_bad++; $display("FAIL drop_ack got %b want 00", {imem.imem_req, if_id_valid});
    end
    tick();
    n_cmp++;
    if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h100}) begin
      n_bad++; $display("FAIL drop_target got %h want %h", {imem.imem_req, imem.imem_addr}, {1'b1, 32'h100});
    end
    tick();
    n_cmp++;
    if ({imem.imem_addr, if_id_valid} !== {32'h104, 1'b0}) begin
      n_bad++; $display("FAIL drop_wait got %h want %h", {imem.imem_addr, if_id_valid}, {32'h104, 1'b0});
    end
    tick();
    exp_ifid = {word(32'h100), 32'h104, 1'b1};
    n_cmp++;
    if ({if_id_ir, if_id_npc, if_id_valid} !== exp_ifid) begin
      n_bad++; $display("FAIL drop_first got %h want %h", {if_id_ir, if_id_npc, if_id_valid}, exp_ifid);
    end
  endtask

  task automatic test_branch_ack_hazard();
    logic [64:0] exp_ifid;
    apply_reset(1'b1);
    repeat (4) tick();
    hazard = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    branch_taken = 1'b0;
    exp_ifid = {32'h0, 32'h8, 1'b0};
    n_cmp++;
    if ({if_id_ir, if_id_npc, if_id_valid, imem.imem_req} !== {exp_ifid, 1'b0}) begin
      n_bad++; $display("FAIL bah_flush got %h want %h", {if_id_ir, if_id_npc, if_id_valid, imem.imem_req}, {exp_ifid, 1'b0});
    end
    tick();
    n_cmp++;
    if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h200}) begin
      n_bad++; $display("FAIL bah_target got %h want %h", {imem.imem_req, imem.imem_addr}, {1'b1, 32'h200});
    end
    hazard = 1'b0;
    tick();
    n_cmp++;
    if ({if_id_ir, if_id_npc, if_id_valid} !== exp_ifid) begin
      n_bad++; $display("FAIL bah_empty got %h want %h", {if_id_ir, if_id_npc, if_id_valid}, exp_ifid);
    end
    tick();
    exp_ifid = {word(32'h200), 32'h204, 1'b1};
    n_cmp++;
    if ({if_id_ir, if_id_npc, if_id_valid} !== exp_ifid) begin
      n_bad++; $display("FAIL bah_first got %h want %h", {if_id_ir, if_id_npc, if_id_valid}, exp_ifid);
    end
  endtask

  task automatic test_wrap();
    logic [64:0] exp_ifid;
    apply_reset(1'b1);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
    tick();
    branch_taken = 1'b0;
    n_cmp++;
    if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'hFFFF_FFF8}) begin
      n_bad++; $display("FAIL wrap_req got %h want %h", {imem.imem_req, imem.imem_addr}, {1'b1, 32'hFFFF_FFF8});
    end
    repeat (2) tick();
    exp_ifid = {word(32'hFFFF_FFF8), 32'hFFFF_FFFC, 1'b1};
    n_cmp++;
    if ({if_id_ir, if_id_npc, if_id_valid, imem.imem_addr} !== {exp_ifid, 32'h0}) begin
      n_bad++; $display("FAIL wrap_first got %h want %h", {if_id_ir, if_id_npc, if_id_valid, imem.imem_addr}, {exp_ifid, 32'h0});
    end
    tick();
    exp_ifid = {word(32'hFFFF_FFFC), 32'h0, 1'b1};
    n_cmp++;
    if ({if_id_ir, if_id_npc, if_id_valid} !== exp_ifid) begin
      n_bad++; $display("FAIL wrap_second got %h want %h", {if_id_ir, if_id_npc, if_id_valid}, exp_ifid);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [64:0] exp_ifid;
    apply_reset(1'b1);
    repeat (4) tick();
    ack_en = 1'b0;
    tick();
    exp_ifid = {word(32'h8), 32'd12, 1'b1};
    n_cmp++;
    if ({if_id_ir, if_id_npc, if_id_valid, imem.imem_req, imem.imem_addr} !== {exp_ifid, 1'b1, 32'd12}) begin
      n_bad++; $display("FAIL rst_pre got %h want %h", {if_id_ir, if_id_npc, if_id_valid, imem.imem_req, imem.imem_addr}, {exp_ifid, 1'b1, 32'd12});
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({if_id_ir, if_id_npc, if_id_valid, imem.imem_req, imem.imem_addr} !== 98'h0) begin
      n_bad++; $display("FAIL rst_async got %h want 0", {if_id_ir, if_id_npc, if_id_valid, imem.imem_req, imem.imem_addr});
    end
    #2;
    reset = 1'b1; ack_en = 1'b1;
    tick();
    n_cmp++;
    if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL rst_restart got %h want %h", {imem.imem_req, imem.imem_addr}, {1'b1, 32'h0});
    end
    repeat (2) tick();
    exp_ifid = {word(32'h0), 32'h4, 1'b1};
    n_cmp++;
    if ({if_id_ir, if_id_npc, if_id_valid} !== exp_ifid) begin
      n_bad++; $display("FAIL rst_first got %h want %h", {if_id_ir, if_id_npc, if_id_valid}, exp_ifid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hazard();
    test_branch_wait();
    test_branch_ack_hazard();
    test_wrap();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
